// File: rtl/hdlc_ctrl_pkg.sv
// Shared definitions for the HDLC controller: register map, Rx_SC bit positions,
// command bytes, FSM state encoding and small helpers.
package hdlc_ctrl_pkg;

  localparam logic [2:0] ADDR_TX_SC   = 3'd0;
  localparam logic [2:0] ADDR_TX_BUFF = 3'd1;
  localparam logic [2:0] ADDR_RX_SC   = 3'd2;
  localparam logic [2:0] ADDR_RX_BUFF = 3'd3;
  localparam logic [2:0] ADDR_RX_LEN  = 3'd4;

  localparam int RX_SC_READY     = 0;
  localparam int RX_SC_DROP      = 1;
  localparam int RX_SC_FRAME_ERR = 2;
  localparam int RX_SC_ABORT     = 3;
  localparam int RX_SC_OVERFLOW  = 5;

  localparam logic [7:0] CMD_TX_START = 8'h02;
  localparam logic [7:0] CMD_RX_DROP  = 8'(1 << RX_SC_DROP);

  typedef enum logic [3:0] {
    IDLE,
    TX_LOAD,
    TX_DROP,
    TX_START,
    TX_WAIT,
    RX_SC,
    RX_LEN,
    RX_DATA,
    RX_OUT,
    RX_DROP
  } ctrlState_t;

  function automatic logic rxFrameBad(input logic [7:0] sc);
    return sc[RX_SC_FRAME_ERR] | sc[RX_SC_ABORT];
  endfunction

  function automatic logic [15:0] satInc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/hdlc_ctrl_arb.sv
// Round-robin grant between the TX and RX sides; TX is preferred after reset and
// the preference flips to the other side each time a grant is taken (done).
module hdlc_ctrl_arb (
  input  logic Clk,
  input  logic Rst,
  input  logic tx_req,
  input  logic rx_req,
  input  logic done,
  output logic grant_tx,
  output logic grant_rx
);

  logic preferRx;

  always_comb begin
    grant_tx = tx_req & (~rx_req | ~preferRx);
    grant_rx = rx_req & (~tx_req | preferRx);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      preferRx <= 1'b0;
    end else if (done) begin
      preferRx <= grant_tx;
    end
  end

endmodule

// File: rtl/hdlc_ctrl.sv
// HDLC controller: moves upstream bytes into the HDLC TX buffer and drains received
// frames to a downstream stream. Define HDLC_CTRL_STATS_EN to build the frame counters.
module hdlc_ctrl
  import hdlc_ctrl_pkg::*;
#(
  parameter int MAX_TX_BYTES = 126,
  parameter int TX_WAIT_TO   = 16
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        TxS_Valid,
  input  logic [7:0]  TxS_Data,
  input  logic        TxS_Last,
  output logic        TxS_Ready,
  output logic        RxM_Valid,
  output logic [7:0]  RxM_Data,
  output logic        RxM_Last,
  output logic        RxM_Err,
  input  logic        RxM_Ready,
  output logic [2:0]  Address,
  output logic        WriteEnable,
  output logic        ReadEnable,
  output logic [7:0]  DataIn,
  input  logic [7:0]  DataOut,
  input  logic        Tx_Done,
  input  logic        Rx_Ready,
  output logic        Busy,
  output logic        TxTrunc,
  output logic [15:0] TxFrameCnt,
  output logic [15:0] RxFrameCnt,
  output logic [15:0] RxErrCnt
);

  localparam int BW = $clog2(MAX_TX_BYTES + 1);
  localparam int WW = $clog2(TX_WAIT_TO + 1);

  ctrlState_t      state;
  logic            grantTx, grantRx, arbDone;
  logic            weReg, reReg, txsReady, phase, overflow, loadWrite;
  logic [2:0]      addrReg;
  logic [7:0]      dinReg, rxLen, rxCnt;
  logic [BW-1:0]   txCnt;
  logic [WW-1:0]   waitCnt;

  assign arbDone = (state == IDLE) & (grantTx | grantRx);

  hdlc_ctrl_arb uArb (
    .Clk      (Clk),
    .Rst      (Rst),
    .tx_req   (TxS_Valid & Tx_Done),
    .rx_req   (Rx_Ready),
    .done     (arbDone),
    .grant_tx (grantTx),
    .grant_rx (grantRx)
  );

  // Payload bytes go onto the bus in the cycle they are accepted, so this path bypasses the registers.
  assign loadWrite   = (state == TX_LOAD) & TxS_Valid;
  assign WriteEnable = weReg | loadWrite;
  assign ReadEnable  = reReg;
  assign Address     = loadWrite ? ADDR_TX_BUFF : addrReg;
  assign DataIn      = loadWrite ? TxS_Data : dinReg;
  assign TxS_Ready   = txsReady;
  assign Busy        = (state != IDLE);

  // Register reads take two cycles in each RX read state: phase 0 strobes, phase 1 samples DataOut.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state     <= IDLE;
      weReg     <= 1'b0;
      reReg     <= 1'b0;
      addrReg   <= '0;
      dinReg    <= '0;
      txsReady  <= 1'b0;
      phase     <= 1'b0;
      overflow  <= 1'b0;
      rxLen     <= '0;
      rxCnt     <= '0;
      txCnt     <= '0;
      waitCnt   <= '0;
      TxTrunc   <= 1'b0;
      RxM_Valid <= 1'b0;
      RxM_Data  <= '0;
      RxM_Last  <= 1'b0;
      RxM_Err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grantTx) begin
            state    <= TX_LOAD;
            txsReady <= 1'b1;
            txCnt    <= '0;
          end else if (grantRx) begin
            state   <= RX_SC;
            reReg   <= 1'b1;
            addrReg <= ADDR_RX_SC;
            phase   <= 1'b0;
          end
        end
        TX_LOAD: begin
          if (TxS_Valid) begin
            txCnt <= txCnt + BW'(1);
            if (TxS_Last) begin
              state    <= TX_START;
              txsReady <= 1'b0;
              weReg    <= 1'b1;
              addrReg  <= ADDR_TX_SC;
              dinReg   <= CMD_TX_START;
            end else if (txCnt == BW'(MAX_TX_BYTES - 1)) begin
              TxTrunc <= 1'b1;
              state   <= TX_DROP;
            end
          end
        end
        TX_DROP: begin
          if (TxS_Valid && TxS_Last) begin
            state    <= TX_START;
            txsReady <= 1'b0;
            weReg    <= 1'b1;
            addrReg  <= ADDR_TX_SC;
            dinReg   <= CMD_TX_START;
          end
        end
        TX_START: begin
          weReg   <= 1'b0;
          waitCnt <= '0;
          state   <= TX_WAIT;
        end
        TX_WAIT: begin
          if (!Tx_Done || waitCnt == WW'(TX_WAIT_TO - 1)) begin
            state <= IDLE;
          end else begin
            waitCnt <= waitCnt + WW'(1);
          end
        end
        RX_SC: begin
          if (!phase) begin
            reReg <= 1'b0;
            phase <= 1'b1;
          end else if (rxFrameBad(DataOut)) begin
            state   <= RX_DROP;
            weReg   <= 1'b1;
            addrReg <= ADDR_RX_SC;
            dinReg  <= CMD_RX_DROP;
          end else begin
            overflow <= DataOut[RX_SC_OVERFLOW];
            state    <= RX_LEN;
            reReg    <= 1'b1;
            addrReg  <= ADDR_RX_LEN;
            phase    <= 1'b0;
          end
        end
        RX_LEN: begin
          if (!phase) begin
            reReg <= 1'b0;
            phase <= 1'b1;
          end else if (DataOut == 8'd0) begin
            state   <= RX_DROP;
            weReg   <= 1'b1;
            addrReg <= ADDR_RX_SC;
            dinReg  <= CMD_RX_DROP;
          end else begin
            rxLen   <= DataOut;
            rxCnt   <= '0;
            state   <= RX_DATA;
            reReg   <= 1'b1;
            addrReg <= ADDR_RX_BUFF;
            phase   <= 1'b0;
          end
        end
        RX_DATA: begin
          if (!phase) begin
            reReg <= 1'b0;
            phase <= 1'b1;
          end else begin
            RxM_Valid <= 1'b1;
            RxM_Data  <= DataOut;
            RxM_Last  <= (rxCnt + 8'd1 == rxLen);
            RxM_Err   <= (rxCnt + 8'd1 == rxLen) & overflow;
            rxCnt     <= rxCnt + 8'd1;
            state     <= RX_OUT;
          end
        end
        RX_OUT: begin
          if (RxM_Ready) begin
            RxM_Valid <= 1'b0;
            RxM_Last  <= 1'b0;
            RxM_Err   <= 1'b0;
            if (RxM_Last) begin
              state <= IDLE;
            end else begin
              state   <= RX_DATA;
              reReg   <= 1'b1;
              addrReg <= ADDR_RX_BUFF;
              phase   <= 1'b0;
            end
          end
        end
        RX_DROP: begin
          weReg <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HDLC_CTRL_STATS_EN
  logic [15:0] txFrames, rxFrames, rxErrors;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      txFrames <= '0;
      rxFrames <= '0;
      rxErrors <= '0;
    end else begin
      if (state == TX_START) txFrames <= satInc(txFrames);
      if (state == RX_OUT && RxM_Ready && RxM_Last) rxFrames <= satInc(rxFrames);
      if (state == RX_DROP) rxErrors <= satInc(rxErrors);
    end
  end

  assign TxFrameCnt = txFrames;
  assign RxFrameCnt = rxFrames;
  assign RxErrCnt   = rxErrors;
`else
  assign TxFrameCnt = '0;
  assign RxFrameCnt = '0;
  assign RxErrCnt   = '0;
`endif

endmodule

// File: doc/hdlc_ctrl.md
HDLC_CTRL -- requirements
Module: hdlc_ctrl

Interface
REQ-001 SHALL have parameter: MAX_TX_BYTES, 126, max payload bytes written to the HDLC TX buffer per frame.
REQ-002 SHALL have parameter: TX_WAIT_TO, 16, cycles to wait for Tx_Done to deassert after TX start.
REQ-003 SHALL have ports: Clk in 1, single clock; Rst in 1, reset, asynchronous, active-low.
REQ-004 SHALL have ports: TxS_Valid in 1, TxS_Data in 8, TxS_Last in 1, TxS_Ready out 1; upstream TX byte stream.
REQ-005 SHALL have ports: RxM_Valid out 1, RxM_Data out 8, RxM_Last out 1, RxM_Err out 1, RxM_Ready in 1; downstream RX byte stream.
REQ-006 SHALL have ports: Address out 3, WriteEnable out 1, ReadEnable out 1, DataIn out 8, DataOut in 8; HDLC register bus.
REQ-007 SHALL have ports: Tx_Done in 1, Rx_Ready in 1; HDLC status pins.
REQ-008 SHALL have ports: Busy out 1; TxTrunc out 1, sticky; TxFrameCnt, RxFrameCnt, RxErrCnt out 16 each.

Function
REQ-009 SHALL use the register map Tx_SC=0, Tx_Buff=1, Rx_SC=2, Rx_Buff=3, Rx_Len=4, with Rx_SC bits Ready=0, Drop=1, FrameError=2, AbortSignal=3, Overflow=5.
REQ-010 SHALL make a bus write a single cycle with WriteEnable=1; a bus read SHALL assert ReadEnable for one cycle and sample DataOut on the following cycle.
REQ-011 SHALL never assert WriteEnable and ReadEnable in the same cycle; both SHALL be 0 in IDLE.
REQ-012 SHALL use FSM states IDLE, TX_LOAD, TX_DROP, TX_START, TX_WAIT, RX_SC, RX_LEN, RX_DATA, RX_OUT, RX_DROP.
REQ-013 SHALL treat TX as pending when TxS_Valid=1 and Tx_Done=1, and RX as pending when Rx_Ready=1.
REQ-014 SHALL, in IDLE, grant the only pending side; when both are pending it SHALL grant the side not served last, and TX SHALL win first after reset.
REQ-015 SHALL, in TX_LOAD, drive TxS_Ready=1 and write each accepted byte to Tx_Buff in the same cycle.
REQ-016 SHALL leave TX_LOAD on TxS_Last and go to TX_START.
REQ-017 SHALL, when MAX_TX_BYTES bytes are accepted without Last, set TxTrunc and go to TX_DROP, which accepts and discards bytes up to and including Last, then goes to TX_START.
REQ-018 SHALL, in TX_START, write 0x02 to Tx_SC for one cycle, then enter TX_WAIT.
REQ-019 SHALL leave TX_WAIT to IDLE when Tx_Done=0 or after TX_WAIT_TO cycles, whichever is first.
REQ-020 SHALL, in RX_SC, read Rx_SC; if FrameError or AbortSignal is set it SHALL go to RX_DROP, otherwise to RX_LEN.
REQ-021 SHALL, in RX_LEN, read Rx_Len; a length of 0 SHALL go to RX_DROP.
REQ-022 SHALL, in RX_DROP, write 0x02 to Rx_SC, increment RxErrCnt, then go to IDLE.
REQ-023 SHALL, in RX_DATA, read Rx_Buff once per byte, and in RX_OUT hold RxM_Valid/Data stable until RxM_Ready=1; only one byte SHALL be outstanding at a time.
REQ-024 SHALL assert RxM_Last on the byte numbered Rx_Len, with RxM_Err=Overflow on that same beat, then return to IDLE.
REQ-025 SHALL drive Busy=1 in every state except IDLE.
REQ-026 SHALL increment TxFrameCnt in TX_START and RxFrameCnt on the Last beat; all counters SHALL saturate at 0xFFFF.

Reset
REQ-027 SHALL, while Rst=0, immediately force state IDLE, all outputs 0, all counters, TxTrunc and the round-robin pointer to 0, regardless of the operation in progress.
REQ-028 SHALL NOT emit any bus or stream activity in the first cycle after Rst deasserts.

Configuration
REQ-029 SHALL, with HDLC_CTRL_STATS_EN defined, implement TxFrameCnt, RxFrameCnt and RxErrCnt as specified.
REQ-030 SHALL, without HDLC_CTRL_STATS_EN, keep those ports, tie them to 0 and omit the counter logic; all other behaviour SHALL be identical.

Structure
REQ-031 SHALL place register addresses, bit positions and the FSM state enum in package hdlc_ctrl_pkg.
REQ-032 SHALL implement the round-robin grant in sub-module hdlc_ctrl_arb (inputs tx_req/rx_req/done, outputs grant_tx/grant_rx).

Verification
REQ-033 SHALL cover: TX frame AA,55,7E with Last and Tx_Done=1 -> Tx_Buff writes AA,55,7E, then Tx_SC write 0x02, TxFrameCnt=1.
REQ-034 SHALL cover: Rx_SC=0x01, Rx_Len=4, bytes 11,22,33,44 with RxM_Ready low 5 cycles -> 4 beats, data held stable, Last on 44, Err=0.
REQ-035 SHALL cover: TX and RX pending together twice -> TX served first, RX served second time.
REQ-036 SHALL cover: Rx_SC=0x05 -> Rx_SC write 0x02, no RxM beats, RxErrCnt=1.
REQ-037 SHALL cover: 130-byte upstream frame -> 126 Tx_Buff writes, 4 bytes discarded, TxTrunc=1, one Tx_SC write.
REQ-038 SHALL cover: Rst low during TX_LOAD -> outputs 0 asynchronously; a following 1-byte frame completes normally.
